// File: rtl/vmu_mult_sched_pkg.sv
// rtl/vmu_mult_sched_pkg.sv - shared widths, scheduler states and product slice for the VMU multiplier scheduler
package vmu_mult_sched_pkg;

  localparam int VMU_DATA_WIDTH = 19;
  localparam int VMU_FRAC_BITS  = 14;
  localparam int VMU_PROD_WIDTH = 2 * VMU_DATA_WIDTH;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Q4.14 x Q4.14 -> Q4.14: keep the sign, drop 14 fraction bits (floor), wrap the integer part.
  function automatic logic [VMU_DATA_WIDTH-1:0] vmu_prod_slice(input logic [VMU_PROD_WIDTH-1:0] p);
    return {p[VMU_PROD_WIDTH-1], p[VMU_DATA_WIDTH+VMU_FRAC_BITS-2:VMU_FRAC_BITS]};
  endfunction

endpackage

// File: rtl/vmu_mult_sched_multiplier.sv
// rtl/vmu_mult_sched_multiplier.sv - registered signed Q4.14 multiplier; DW is tied to VMU_DATA_WIDTH by the slice
module multiplier
  import vmu_mult_sched_pkg::*;
#(
  parameter int DW = VMU_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p
);

  logic signed [2*DW-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p <= '0;
    else     p <= vmu_prod_slice(prod);
  end

endmodule

// File: rtl/vmu_mult_sched_rr_arbiter.sv
// rtl/vmu_mult_sched_rr_arbiter.sv - combinational round-robin pick of the first request after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int c;

  // Scan from farthest to nearest so the candidate closest after ptr is the last one written.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/vmu_mult_sched.sv
// rtl/vmu_mult_sched.sv - shares one multiplier among NUM_REQ requesters with round-robin and burst lock
module vmu_mult_sched
  import vmu_mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = VMU_DATA_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DW-1:0] req_din1,
  input  logic [NUM_REQ*DW-1:0] req_din2,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  rsp_last,
  output logic                  locked,
  output logic [ID_W-1:0]       grant_id
);

  logic [0:0]         state;
  logic [ID_W-1:0]    owner, rr_ptr, arb_idx, gidx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               grant, gnt_last, mult_rst;
  logic [DW-1:0]      op_a, op_b;
  logic               tag_valid, tag_last;
  logic [ID_W-1:0]    tag_id;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Ready never looks at operand data, only valid, state and the pointer.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (state == ST_IDLE)    req_ready = arb_gnt;
      else if (req_valid[owner]) req_ready[owner] = 1'b1;
    end
  end

  assign grant    = |(req_valid & req_ready);
  assign gidx     = (state == ST_LOCKED) ? owner : arb_idx;
  assign gnt_last = req_last[gidx];
  assign op_a     = grant ? req_din1[gidx*DW +: DW] : '0;
  assign op_b     = grant ? req_din2[gidx*DW +: DW] : '0;
  assign mult_rst = ~rst_n;

  multiplier #(.DW(DW)) u_mult (
    .clk (clk),
    .rst (mult_rst),
    .a   (op_a),
    .b   (op_b),
    .p   (rsp_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      tag_valid <= 1'b0;
      tag_id    <= '0;
      tag_last  <= 1'b0;
    end else begin
      tag_valid <= grant;
      tag_id    <= gidx;
      tag_last  <= grant & gnt_last;
      if (grant) begin
        grant_id <= gidx;
        if (!gnt_last) begin
          state <= ST_LOCKED;
          owner <= gidx;
        end else begin
          // Burst ends and single beats both move the pointer to the granted index.
          state  <= ST_IDLE;
          rr_ptr <= gidx;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_valid) rsp_valid[tag_id] = 1'b1;
  end

  assign rsp_last = tag_last;
  assign locked   = (state == ST_LOCKED);

endmodule

// File: tb/tb_vmu_mult_sched.sv
// tb/tb_vmu_mult_sched.sv - directed self-checking bench for vmu_mult_sched
module tb_vmu_mult_sched;

  localparam int N  = 4;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  rv, rl;
  logic [DW-1:0] a1 [N];
  logic [DW-1:0] a2 [N];
  logic [N*DW-1:0] din1, din2;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_last, locked;
  logic [1:0]    grant_id;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign din1 = {a1[3], a1[2], a1[1], a1[0]};
  assign din2 = {a2[3], a2[2], a2[1], a2[0]};

  vmu_mult_sched #(.NUM_REQ(N), .DW(DW), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_last  (rl),
    .req_din1  (din1),
    .req_din2  (din2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .locked    (locked),
    .grant_id  (grant_id)
  );

  task automatic clear_inputs;
    rv = '0;
    rl = '0;
    for (int i = 0; i < N; i++) begin
      a1[i] = '0;
      a2[i] = '0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    rv = 4'b1111;
    rl = 4'b1111;
    #2;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", req_ready); else passed++; total++;
    if (locked !== 1'b0) $display("FAIL reset_locked got %b exp 0", locked); else passed++; total++;
    if (grant_id !== 2'd0) $display("FAIL reset_grant_id got %0d exp 0", grant_id); else passed++; total++;
    if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else passed++; total++;
    if (rsp_data !== 19'd0) $display("FAIL reset_rsp_data got %h exp 0", rsp_data); else passed++; total++;
    if (rsp_last !== 1'b0) $display("FAIL reset_rsp_last got %b exp 0", rsp_last); else passed++; total++;
    tick();
    tick();
    if (req_ready !== 4'b0000) $display("FAIL reset_ready_clocked got %b exp 0000", req_ready); else passed++; total++;
    if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_clocked got %b exp 0000", rsp_valid); else passed++; total++;
    clear_inputs();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single;
    rv = 4'b0001;
    rl = 4'b0001;
    a1[0] = 19'd24576;
    a2[0] = 19'd32768;
    #1;
    if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else passed++; total++;
    tick();
    clear_inputs();
    #1;
    if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); else passed++; total++;
    if (rsp_data !== 19'd49152) $display("FAIL single_rsp_data got %0d exp 49152", rsp_data); else passed++; total++;
    if (rsp_last !== 1'b1) $display("FAIL single_rsp_last got %b exp 1", rsp_last); else passed++; total++;
    if (grant_id !== 2'd0) $display("FAIL single_grant_id got %0d exp 0", grant_id); else passed++; total++;
    tick();
    if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_once got %b exp 0000", rsp_valid); else passed++; total++;
  endtask

  task automatic test_round_robin;
    do_reset();
    rv = 4'b1111;
    rl = 4'b1111;
    for (int i = 0; i < N; i++) begin
      a1[i] = 19'(16384 * (i + 1));
      a2[i] = 19'd16384;
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready !== 4'(1 << (c % 4)))
        $display("FAIL rr_ready cycle %0d got %b exp %b", c, req_ready, 4'(1 << (c % 4)));
      else passed++;
      total++;
      if (c > 0) begin
        if (rsp_valid !== 4'(1 << ((c - 1) % 4)))
          $display("FAIL rr_rsp_valid cycle %0d got %b exp %b", c, rsp_valid, 4'(1 << ((c - 1) % 4)));
        else passed++;
        total++;
        if (rsp_data !== 19'((((c - 1) % 4) + 1) * 16384))
          $display("FAIL rr_rsp_data cycle %0d got %0d exp %0d", c, rsp_data, (((c - 1) % 4) + 1) * 16384);
        else passed++;
        total++;
      end
      tick();
    end
    clear_inputs();
    #1;
    if (rsp_valid !== 4'b1000) $display("FAIL rr_last_rsp got %b exp 1000", rsp_valid); else passed++; total++;
    if (rsp_data !== 19'd65536) $display("FAIL rr_last_data got %0d exp 65536", rsp_data); else passed++; total++;
  endtask

  task automatic test_burst_lock;
    clear_inputs();
    rv = 4'b0100;
    rl = 4'b0000;
    a1[2] = 19'd16384;
    a2[2] = 19'd32768;
    a1[0] = 19'd16384;
    a2[0] = 19'd16384;
    a1[3] = 19'd49152;
    a2[3] = 19'd16384;
    #1;
    if (req_ready !== 4'b0100) $display("FAIL burst_first_ready got %b exp 0100", req_ready); else passed++; total++;
    tick();
    rv = 4'b1111;
    rl = 4'b1011;
    for (int b = 2; b <= 4; b++) begin
      if (b == 4) rl[2] = 1'b1;
      #1;
      if (req_ready !== 4'b0100) $display("FAIL burst_ready beat %0d got %b exp 0100", b, req_ready); else passed++; total++;
      if (locked !== 1'b1) $display("FAIL burst_locked beat %0d got %b exp 1", b, locked); else passed++; total++;
      if (rsp_valid !== 4'b0100) $display("FAIL burst_rsp_valid beat %0d got %b exp 0100", b, rsp_valid); else passed++; total++;
      if (rsp_data !== 19'd32768) $display("FAIL burst_rsp_data beat %0d got %0d exp 32768", b, rsp_data); else passed++; total++;
      if (rsp_last !== 1'b0) $display("FAIL burst_rsp_last beat %0d got %b exp 0", b, rsp_last); else passed++; total++;
      tick();
    end
    rv[2] = 1'b0;
    #1;
    if (locked !== 1'b0) $display("FAIL burst_unlock got %b exp 0", locked); else passed++; total++;
    if (rsp_last !== 1'b1) $display("FAIL burst_final_last got %b exp 1", rsp_last); else passed++; total++;
    if (req_ready !== 4'b1000) $display("FAIL burst_next_req3 got %b exp 1000", req_ready); else passed++; total++;
    tick();
    rv[3] = 1'b0;
    #1;
    if (rsp_valid !== 4'b1000) $display("FAIL burst_req3_rsp got %b exp 1000", rsp_valid); else passed++; total++;
    if (rsp_data !== 19'd49152) $display("FAIL burst_req3_data got %0d exp 49152", rsp_data); else passed++; total++;
    if (req_ready !== 4'b0001) $display("FAIL burst_then_req0 got %b exp 0001", req_ready); else passed++; total++;
    tick();
    clear_inputs();
    #1;
    if (rsp_valid !== 4'b0001) $display("FAIL burst_req0_rsp got %b exp 0001", rsp_valid); else passed++; total++;
    tick();
  endtask

  task automatic test_owner_bubble;
    clear_inputs();
    rv = 4'b0011;
    rl = 4'b0001;
    a1[1] = 19'd16384;
    a2[1] = 19'd16384;
    #1;
    if (req_ready !== 4'b0010) $display("FAIL bubble_first_ready got %b exp 0010", req_ready); else passed++; total++;
    tick();
    rv = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (req_ready !== 4'b0000) $display("FAIL bubble_ready cycle %0d got %b exp 0000", k, req_ready); else passed++; total++;
      if (locked !== 1'b1) $display("FAIL bubble_locked cycle %0d got %b exp 1", k, locked); else passed++; total++;
      if (rsp_valid !== ((k == 0) ? 4'b0010 : 4'b0000))
        $display("FAIL bubble_rsp cycle %0d got %b exp %b", k, rsp_valid, (k == 0) ? 4'b0010 : 4'b0000);
      else passed++;
      total++;
      tick();
    end
    rv = 4'b0011;
    rl = 4'b0011;
    #1;
    if (req_ready !== 4'b0010) $display("FAIL bubble_resume_ready got %b exp 0010", req_ready); else passed++; total++;
    if (rsp_valid !== 4'b0000) $display("FAIL bubble_third_idle got %b exp 0000", rsp_valid); else passed++; total++;
    tick();
    rv = 4'b0001;
    #1;
    if (rsp_valid !== 4'b0010) $display("FAIL bubble_end_rsp got %b exp 0010", rsp_valid); else passed++; total++;
    if (rsp_last !== 1'b1) $display("FAIL bubble_end_last got %b exp 1", rsp_last); else passed++; total++;
    if (locked !== 1'b0) $display("FAIL bubble_unlock got %b exp 0", locked); else passed++; total++;
    if (req_ready !== 4'b0001) $display("FAIL bubble_req0_ready got %b exp 0001", req_ready); else passed++; total++;
    tick();
    clear_inputs();
    #1;
    if (rsp_valid !== 4'b0001) $display("FAIL bubble_req0_rsp got %b exp 0001", rsp_valid); else passed++; total++;
    tick();
  endtask

  task automatic test_sign_trunc;
    logic [DW-1:0] ops1 [3];
    logic [DW-1:0] ops2 [3];
    logic [DW-1:0] exps [3];
    ops1[0] = 19'h7C000;  ops2[0] = 19'd1;     exps[0] = 19'h7FFFF;
    ops1[1] = 19'h7A000;  ops2[1] = 19'd32768; exps[1] = 19'h74000;
    ops1[2] = 19'd65536;  ops2[2] = 19'd65536; exps[2] = 19'd0;
    for (int t = 0; t < 3; t++) begin
      clear_inputs();
      rv = 4'b0001;
      rl = 4'b0001;
      a1[0] = ops1[t];
      a2[0] = ops2[t];
      tick();
      clear_inputs();
      #1;
      if (rsp_valid !== 4'b0001) $display("FAIL sign_rsp_valid case %0d got %b exp 0001", t, rsp_valid); else passed++; total++;
      if (rsp_data !== exps[t]) $display("FAIL sign_rsp_data case %0d got %h exp %h", t, rsp_data, exps[t]); else passed++; total++;
      tick();
    end
  endtask

  task automatic test_reset_mid_burst;
    clear_inputs();
    rv = 4'b0100;
    rl = 4'b0000;
    a1[2] = 19'd16384;
    a2[2] = 19'd16384;
    tick();
    #1;
    if (locked !== 1'b1) $display("FAIL midrst_locked got %b exp 1", locked); else passed++; total++;
    tick();
    rst_n = 1'b0;
    rv = 4'b0101;
    rl = 4'b0101;
    a1[0] = 19'd32768;
    a2[0] = 19'd16384;
    #1;
    if (rsp_valid !== 4'b0000) $display("FAIL midrst_rsp_valid got %b exp 0000", rsp_valid); else passed++; total++;
    if (locked !== 1'b0) $display("FAIL midrst_locked_clr got %b exp 0", locked); else passed++; total++;
    if (req_ready !== 4'b0000) $display("FAIL midrst_ready got %b exp 0000", req_ready); else passed++; total++;
    tick();
    if (rsp_valid !== 4'b0000) $display("FAIL midrst_rsp_held got %b exp 0000", rsp_valid); else passed++; total++;
    rst_n = 1'b1;
    #1;
    if (req_ready !== 4'b0001) $display("FAIL midrst_req0_first got %b exp 0001", req_ready); else passed++; total++;
    tick();
    clear_inputs();
    #1;
    if (rsp_valid !== 4'b0001) $display("FAIL midrst_req0_rsp got %b exp 0001", rsp_valid); else passed++; total++;
    if (rsp_data !== 19'd32768) $display("FAIL midrst_req0_data got %0d exp 32768", rsp_data); else passed++; total++;
    if (rsp_last !== 1'b1) $display("FAIL midrst_req0_last got %b exp 1", rsp_last); else passed++; total++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_owner_bubble();
    test_sign_trunc();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
